mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / divide unit owning the HI and LO
// registers. Multiply is a 32-step shift-add and divide a 32-step restoring
// division, both on operand magnitudes, with the sign fixed up in a final
// cycle that also commits HI/LO. MTHI/MTLO write HI/LO directly when idle.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  fncode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic        is_div_q;     // operation kind captured at accept
    logic        div_zero_q;   // divisor was zero: commit nothing
    logic        neg_res_q;    // product sign, or quotient sign
    logic        neg_rem_q;    // remainder sign (sign of dividend)
    logic [31:0] opnd_q;       // multiplicand or divisor magnitude
    logic [63:0] acc_q;        // {upper, lower} working register
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Request decode and operand magnitudes
    logic        req_mul;
    logic        req_div;
    logic        req_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    // Per-iteration next values and sign-corrected results
    logic [32:0] mul_sum;
    logic [63:0] mul_d;
    logic        div_ge;
    logic [31:0] div_rem_d;
    logic [63:0] div_d;
    logic [63:0] acc_d;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Decode the request and form operand magnitudes for the signed forms
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        req_mul    = 1'b0;
        req_div    = 1'b0;
        req_signed = 1'b0;
        case (fncode)
            FN_MULT:  begin req_mul = 1'b1; req_signed = 1'b1; end
            FN_MULTU: req_mul = 1'b1;
            FN_DIV:   begin req_div = 1'b1; req_signed = 1'b1; end
            FN_DIVU:  req_div = 1'b1;
            default:  ;
        endcase
        mag_a = (req_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
        mag_b = (req_signed && op_b[31]) ? (32'd0 - op_b) : op_b;
    end

    // One iteration of shift-add multiply or restoring divide, plus fix-up values
    always_comb begin
        // Multiply: multiplier in the low half, shifted out LSB first; the
        // partial product accumulates in the high half with its carry.
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_d   = {mul_sum, acc_q[31:1]};

        // Divide: remainder in the high half, dividend/quotient in the low
        // half. Shift one dividend bit into the remainder and try a subtract.
        div_ge    = acc_q[63:31] >= {1'b0, opnd_q};
        div_rem_d = div_ge ? (acc_q[62:31] - opnd_q) : acc_q[62:31];
        div_d     = {div_rem_d, acc_q[30:0], div_ge};

        acc_d = is_div_q ? div_d : mul_d;

        prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
        quo_fix  = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    // Control FSM with datapath and architectural HI/LO
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            // NOTE: datapath registers are cleared too, so an aborted operation leaves no stale state behind.
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            opnd_q     <= 32'd0;
            acc_q      <= 64'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (fncode == FN_MTHI) begin
                            hi_q <= op_a;
                        end else if (fncode == FN_MTLO) begin
                            lo_q <= op_a;
                        end else if (req_mul || req_div) begin
                            state_q    <= S_ITER;
                            busy_q     <= 1'b1;
                            cnt_q      <= 5'd0;
                            is_div_q   <= req_div;
                            div_zero_q <= req_div && (op_b == 32'd0);
                            neg_res_q  <= req_signed && (op_a[31] ^ op_b[31]);
                            neg_rem_q  <= req_signed && op_a[31];
                            opnd_q     <= req_div ? mag_b : mag_a;
                            acc_q      <= {32'd0, req_div ? mag_a : mag_b};
                        end
                    end
                end
                S_ITER: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end else if (!div_zero_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
